// File: rtl/memory_bus_dma.sv
// Bus-initiator DMA: copies a byte block from src to dst over memory_bus, one read + one write per byte.
// Define MEMORY_BUS_DMA_FILL_EN to build the constant-fill mode (back-to-back writes of fill_value).
module memory_bus_dma #(
    parameter int unsigned READ_WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] src_address,
    input  logic [23:0] dst_address,
    input  logic [15:0] length,
    input  logic        fill_mode,
    input  logic [7:0]  fill_value,
    output logic [23:0] address,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        bus_enable,
    output logic        write_enable,
    input  logic        bus_halt,
    output logic        busy,
    output logic        done
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 16;
    localparam int unsigned WW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [AW-1:0] address_q, address_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          bus_enable_q, bus_enable_d;
    logic          write_enable_q, write_enable_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          fill_sel;
    logic [DW-1:0] fill_byte;

    assign accept = start && (state_q == S_IDLE) && !busy_q;

`ifdef MEMORY_BUS_DMA_FILL_EN
    logic          fill_q, fill_d;
    logic [DW-1:0] fill_byte_q, fill_byte_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= 1'b0;
            fill_byte_q <= '0;
        end else begin
            fill_q      <= fill_d;
            fill_byte_q <= fill_byte_d;
        end
    end

    always_comb begin
        fill_d      = fill_q;
        fill_byte_d = fill_byte_q;
        if (accept) begin
            fill_d      = fill_mode;
            fill_byte_d = fill_value;
        end
    end

    assign fill_sel  = fill_q;
    assign fill_byte = fill_byte_q;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_mode, fill_value};
    assign fill_sel    = 1'b0;
    assign fill_byte   = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            remaining_q    <= '0;
            wait_q         <= '0;
            address_q      <= '0;
            data_out_q     <= '0;
            bus_enable_q   <= 1'b0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            remaining_q    <= remaining_d;
            wait_q         <= wait_d;
            address_q      <= address_d;
            data_out_q     <= data_out_d;
            bus_enable_q   <= bus_enable_d;
            write_enable_q <= write_enable_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Bus outputs are computed for the state being entered so they are registered in that state.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        remaining_d    = remaining_q;
        wait_d         = wait_q;
        address_d      = address_q;
        data_out_d     = data_out_q;
        bus_enable_d   = bus_enable_q;
        write_enable_d = write_enable_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    // Setup cycle: parameters were latched on the previous edge
                    if (remaining_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (fill_sel) begin
                        state_d        = S_WRITE;
                        address_d      = dst_q;
                        data_out_d     = fill_byte;
                        bus_enable_d   = 1'b1;
                        write_enable_d = 1'b1;
                    end else begin
                        state_d        = S_READ;
                        address_d      = src_q;
                        bus_enable_d   = 1'b1;
                        write_enable_d = 1'b0;
                    end
                end else if (accept) begin
                    src_d       = src_address;
                    dst_d       = dst_address;
                    remaining_d = length;
                    wait_d      = '0;
                    busy_d      = 1'b1;
                end
            end
            S_READ: begin
                if (!bus_halt) begin
                    if (wait_q == WW'(READ_WAIT_CYCLES)) begin
                        wait_d         = '0;
                        state_d        = S_WRITE;
                        address_d      = dst_q;
                        data_out_d     = data_in;
                        write_enable_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (!bus_halt) begin
                    src_d       = src_q + AW'(1);
                    dst_d       = dst_q + AW'(1);
                    remaining_d = remaining_q - LW'(1);
                    if (remaining_q == LW'(1)) begin
                        state_d        = S_DONE;
                        bus_enable_d   = 1'b0;
                        write_enable_d = 1'b0;
                        done_d         = 1'b1;
                    end else if (fill_sel) begin
                        address_d = dst_q + AW'(1);
                    end else begin
                        state_d        = S_READ;
                        address_d      = src_q + AW'(1);
                        write_enable_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address      = address_q;
    assign data_out     = data_out_q;
    assign bus_enable   = bus_enable_q;
    assign write_enable = write_enable_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_memory_bus_dma.sv
// Scoreboard bench for memory_bus_dma: expected reads/writes queued at start, popped as the bus shows them.
module tb_memory_bus_dma;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] src_address;
    logic [23:0] dst_address;
    logic [15:0] length;
    logic        fill_mode;
    logic [7:0]  fill_value;
    logic [23:0] address;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        bus_enable;
    logic        write_enable;
    logic        bus_halt;
    logic        busy;
    logic        done;

    logic [7:0]  src_mem [16];
    logic [23:0] exp_rd [$];
    logic [31:0] exp_wr [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;
    int n_writes = 0;
    int be_cnt   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int lat;
    bit prev_rd  = 1'b0;

    memory_bus_dma dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_address  (src_address),
        .dst_address  (dst_address),
        .length       (length),
        .fill_mode    (fill_mode),
        .fill_value   (fill_value),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .bus_halt     (bus_halt),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Source memory model: byte selected by the low address nibble
    assign data_in = src_mem[address[3:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: one read per new read phase, one write per unstalled write cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (bus_enable) be_cnt++;
            if (bus_enable && !write_enable && !prev_rd) begin
                n_reads++;
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(address), 'x);
                else check("rd_addr", 32'(address), 32'(exp_rd.pop_front()));
            end
            if (bus_enable && write_enable && !bus_halt) begin
                n_writes++;
                if (exp_wr.size() == 0) check("wr_unexpected", {address, data_out}, 'x);
                else check("wr_addr_data", {address, data_out}, exp_wr.pop_front());
            end
        end
        prev_rd = bus_enable && !write_enable;
    end

    task automatic push_copy(input logic [23:0] src, input logic [23:0] dst, input int len);
        logic [23:0] a;
        for (int i = 0; i < len; i++) begin
            a = 24'(src + 24'(i));
            exp_rd.push_back(a);
            exp_wr.push_back({24'(dst + 24'(i)), src_mem[a[3:0]]});
        end
    endtask

    task automatic push_fill(input logic [23:0] dst, input int len, input logic [7:0] val);
        for (int i = 0; i < len; i++) exp_wr.push_back({24'(dst + 24'(i)), val});
    endtask

    task automatic clear_counts();
        n_reads = 0; n_writes = 0; be_cnt = 0; busy_cnt = 0; done_cnt = 0;
    endtask

    task automatic drive_start(input logic [23:0] src, input logic [23:0] dst, input logic [15:0] len,
                               input logic fm, input logic [7:0] fv);
        src_address = src; dst_address = dst; length = len;
        fill_mode = fm; fill_value = fv; start = 1'b1;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (!done && cycles < bound) begin
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic finish_xfer(input string tag, input int exp_busy);
        @(posedge clk); #1;
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src_mem[i] = 8'((i + 1) * 17);
        reset = 1'b1; start = 1'b0; bus_halt = 1'b0;
        src_address = '0; dst_address = '0; length = '0; fill_mode = 1'b0; fill_value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_address", 32'(address), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_strobes", 32'({bus_enable, write_enable}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 4-byte copy; a second start during setup with other parameters must be ignored
        clear_counts();
        push_copy(24'h010000, 24'h008000, 4);
        drive_start(24'h010000, 24'h008000, 16'd4, 1'b0, 8'h00);
        @(posedge clk); #1;
        drive_start(24'h000003, 24'h123456, 16'd7, 1'b0, 8'h00);
        wait_done(200, lat);
        finish_xfer("copy4", 14);

        // Zero length: done two cycles after start, no bus activity
        clear_counts();
        drive_start(24'h010000, 24'h008000, 16'd0, 1'b0, 8'h00);
        wait_done(50, lat);
        check("zero_latency", 32'(lat), 32'd2);
        finish_xfer("zero", 2);
        check("zero_no_bus", 32'(be_cnt), 32'd0);

        // 2-byte copy unstalled, then the same with a 5-cycle halt in the second read
        clear_counts();
        push_copy(24'h010004, 24'h008100, 2);
        drive_start(24'h010004, 24'h008100, 16'd2, 1'b0, 8'h00);
        wait_done(200, lat);
        finish_xfer("copy2", 8);

        clear_counts();
        push_copy(24'h010004, 24'h008100, 2);
        drive_start(24'h010004, 24'h008100, 16'd2, 1'b0, 8'h00);
        lat = 0;
        while (n_reads < 2 && lat < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check("stall_found_read2", 32'(n_reads), 32'd2);
        bus_halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", 32'(address), 32'h010005);
            check("stall_strobes", 32'({bus_enable, write_enable}), 32'b10);
            @(posedge clk); #1;
        end
        bus_halt = 1'b0;
        wait_done(200, lat);
        finish_xfer("stall", 13);

        // Address wrap at 2^24 on both pointers
        clear_counts();
        push_copy(24'hFFFFFF, 24'h00BFFF, 2);
        drive_start(24'hFFFFFF, 24'h00BFFF, 16'd2, 1'b0, 8'h00);
        wait_done(200, lat);
        finish_xfer("wrap", 8);

        // Reset during the third write of a 10-byte copy
        clear_counts();
        push_copy(24'h010004, 24'h009000, 10);
        drive_start(24'h010004, 24'h009000, 16'd10, 1'b0, 8'h00);
        lat = 0;
        while (!(n_writes >= 2 && bus_enable && write_enable) && lat < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check("rstmid_in_write", 32'({bus_enable, write_enable}), 32'b11);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_strobes", 32'({bus_enable, write_enable}), 32'd0);
        check("rstmid_busy_done", 32'({busy, done}), 32'd0);
        reset = 1'b0;
        exp_wr.delete();
        exp_rd.delete();
        done_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_no_done", 32'(done_cnt), 32'd0);
        check("rstmid_idle", 32'({busy, bus_enable}), 32'd0);

        // Start coincident with reset is ignored
        reset = 1'b1;
        drive_start(24'h010000, 24'h00A000, 16'd3, 1'b0, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rststart_ignored", 32'({busy, bus_enable}), 32'd0);

        // Normal copy after the reset
        clear_counts();
        push_copy(24'h010000, 24'h008000, 4);
        drive_start(24'h010000, 24'h008000, 16'd4, 1'b0, 8'h00);
        wait_done(200, lat);
        finish_xfer("copy_after_rst", 14);

        // fill_mode request: fills when the feature is built, otherwise behaves as a copy
        clear_counts();
`ifdef MEMORY_BUS_DMA_FILL_EN
        push_fill(24'h008010, 3, 8'hA5);
        drive_start(24'h010000, 24'h008010, 16'd3, 1'b1, 8'hA5);
        wait_done(200, lat);
        finish_xfer("fill", 5);
        check("fill_no_reads", 32'(n_reads), 32'd0);
`else
        push_copy(24'h010000, 24'h008010, 3);
        drive_start(24'h010000, 24'h008010, 16'd3, 1'b1, 8'hA5);
        wait_done(200, lat);
        finish_xfer("fill_ignored", 11);
        check("fill_ignored_reads", 32'(n_reads), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_bus_dma.md
Name: memory_bus_dma

Overview:
- Bus initiator (DMA) that drives the same bus signals the CPU drives toward memory_bus: address, data, bus_enable, write_enable; honours bus_halt.
- Copies a block of bytes from a 24-bit source address (typically SD card / flash space, upper_page != 0 or bank 3) to a 24-bit destination address (typically RAM bank 2).
- Sits beside the CPU; the top level muxes bus ownership to this block while busy is high.
- Optional fill mode writes a constant instead of copying.

Parameters:
- READ_WAIT_CYCLES, 1, cycles between presenting a read address and sampling read data; range 1-7; covers registered block RAM on raw_clk.

Ports:
- clk  input  1  system clock, same clk as the CPU/memory_bus side.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request; accepted only in IDLE.
- src_address  input  24  source start address, sampled on accepted start.
- dst_address  input  24  destination start address, sampled on accepted start.
- length  input  16  byte count, sampled on accepted start; 0 allowed.
- fill_mode  input  1  sampled on start; used only with MEMORY_BUS_DMA_FILL_EN.
- fill_value  input  8  sampled on start; used only with MEMORY_BUS_DMA_FILL_EN.
- address  output  24  bus address (registered).
- data_out  output  8  write data to the bus data_in (registered).
- data_in  input  8  read data from the bus data_out.
- bus_enable  output  1  bus request strobe (registered).
- write_enable  output  1  write strobe (registered).
- bus_halt  input  1  stall from the bus: SD busy or video wait.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- done  output  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset values: address 0, data_out 0, bus_enable 0, write_enable 0, busy 0, done 0; state IDLE; internal counters 0.
- Reset has priority over everything. Reset mid-transfer returns to IDLE next edge with bus_enable=0, write_enable=0 and no done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 latches src, dst and remaining=length, and sets busy=1.
  - length==0 goes to DONE with no bus cycles.
  - Otherwise goes to READ (copy) or WRITE (fill).
  - start while not in IDLE is ignored.
- READ:
  - address=src, bus_enable=1, write_enable=0.
  - wait_count increments on each cycle with bus_halt=0.
  - When wait_count==READ_WAIT_CYCLES and bus_halt=0, capture data_in into byte_reg, clear wait_count, and go to WRITE.
  - Unstalled, this takes READ_WAIT_CYCLES+1 cycles.
- WRITE:
  - address=dst, data_out=byte_reg, bus_enable=1, write_enable=1.
  - The write completes on the first cycle with bus_halt=0. Then src+=1, dst+=1, remaining-=1.
  - If remaining was 1, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- Stall: while bus_halt=1, address, data_out, bus_enable and write_enable hold unchanged, and no counter or pointer advances.
- DONE: bus_enable=0, write_enable=0, done=1 for exactly one cycle, busy=0 on the following cycle, then go to IDLE.
- Throughput with default parameter and no halt: 3 clk per copied byte; 1 clk per filled byte.
- Arithmetic:
  - src and dst increment modulo 2^24 (0xFFFFFF wraps to 0x000000); no carry out.
  - remaining is 16-bit, so the maximum transfer is 65535 bytes.
- Simultaneous events:
  - bus_halt rising in the same cycle the read data would be sampled: sampling is deferred.
  - start in the same cycle as reset: ignored.

Optional Feature:
- Macro: MEMORY_BUS_DMA_FILL_EN.
- Defined: fill_mode=1 at start skips READ; byte_reg=fill_value, and the block goes straight to WRITE, issuing back-to-back writes to consecutive dst addresses. src is unused.
- Undefined: fill_mode and fill_value are ignored, every transfer is a copy, and no fill logic is synthesised.

Test Plan:
- Copy: src=0x010000, dst=0x008000, length=4; source model returns 0x11,0x22,0x33,0x44 → four writes to 0x008000-0x008003 with those bytes; done pulses once; busy high for 14 cycles (1 setup + 12 transfer + 1 DONE), bus_halt=0.
- Zero length: length=0 → no cycle with bus_enable=1; done pulses 2 cycles after start; busy low afterwards.
- Stall: bus_halt held high 5 cycles during the second READ of a 2-byte copy → address and strobes constant through the stall; correct byte written; total time 5 cycles longer than unstalled.
- Wrap: src=0xFFFFFF, dst=0x00BFFF, length=2 → reads from 0xFFFFFF then 0x000000; writes to 0x00BFFF then 0x00C000.
- Reset mid-transfer: reset asserted during a WRITE of a 10-byte copy → next edge bus_enable=0, write_enable=0, busy=0, no done; a new start afterwards completes normally.
- Fill (MEMORY_BUS_DMA_FILL_EN defined): fill_mode=1, fill_value=0xA5, dst=0x008010, length=3 → three consecutive write cycles of 0xA5 to 0x008010-0x008012; no read cycles; done pulses once.
